// File: rtl/axi_apb_write_slave.sv
// AXI write responder: accepts one AW + BURST_LEN W beats, replays them as APB writes, then one B.
// Optional `ifdef AXI2APB_BRESP_EN adds bresp (SLVERR when any APB beat of the burst reported pslverr).
module axi_apb_write_slave #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int BURST_LEN  = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic              awvalid,
   output logic              awready,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wvalid,
   output logic              wready,
   output logic              bvalid,
   input  logic              bready,
`ifdef AXI2APB_BRESP_EN
   output logic [1:0]        bresp,
`endif
   output logic [ADDR_W-1:0] paddr,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [DATA_W-1:0] pwdata,
   input  logic              pready,
   input  logic              pslverr,
   output logic [1:0]        o_dbg_burst_state,
   output logic [1:0]        o_dbg_apb_state,
   output logic              o_dbg_err
);

   localparam int CW = $clog2(BURST_LEN + 1);
   localparam int PW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, RESP = 2'd2} burst_state_t;
   typedef enum logic [1:0] {AIDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} apb_state_t;

   burst_state_t r_state, w_state_nxt;
   apb_state_t   r_apb, w_apb_nxt;

   logic              r_awready;
   logic [ADDR_W-1:0] r_base;
   logic [CW-1:0]     r_wr_cnt, r_rd_cnt, w_beat;
   logic              r_err;

   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]     r_wptr, r_rptr;
   logic [PW:0]       r_count;

   logic              w_aw_hs, w_push, w_pop, w_last_pop, w_full, w_more, w_enter_setup;
   logic [DATA_W-1:0] w_head, w_nxt_head, w_setup_data;

   // Valid/ready: a beat moves only when valid && ready are both high at a rising clk edge;
   // the source holds valid and payload stable until then.
   assign w_aw_hs    = awvalid && r_awready;
   assign w_push     = wvalid && wready;
   assign w_pop      = (r_apb == ACCESS) && pready;
   assign w_last_pop = w_pop && (r_rd_cnt == CW'(BURST_LEN - 1));
   assign w_full     = (r_count == (PW+1)'(FIFO_DEPTH));
   assign w_head     = r_mem[r_rptr];
   assign w_nxt_head = (r_count > (PW+1)'(1)) ? r_mem[r_rptr + PW'(1)] : wdata;
   assign w_more     = (r_count > (PW+1)'(1)) || w_push;

   assign awready = r_awready;
   assign bvalid  = (r_state == RESP);
`ifdef AXI2APB_BRESP_EN
   assign bresp   = (bvalid && r_err) ? 2'b10 : 2'b00;
`endif
   assign o_dbg_burst_state = r_state;
   assign o_dbg_apb_state   = r_apb;
   assign o_dbg_err         = r_err;

   always_comb begin
      w_state_nxt = r_state;
      wready      = 1'b0;
      case (r_state)
         IDLE:  if (w_aw_hs) w_state_nxt = BURST;
         BURST: begin
            wready = !w_full && (r_wr_cnt < CW'(BURST_LEN));
            if (w_last_pop) w_state_nxt = RESP;
         end
         RESP:  if (bready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_apb_nxt = r_apb;
      case (r_apb)
         AIDLE:  if ((r_state == BURST) && (r_count != '0)) w_apb_nxt = SETUP;
         SETUP:  w_apb_nxt = ACCESS;
         ACCESS: if (pready) w_apb_nxt = w_more ? SETUP : AIDLE;
         default: w_apb_nxt = AIDLE;
      endcase
   end

   // A SETUP entered straight from ACCESS presents the beat after the one being popped.
   assign w_enter_setup = (w_apb_nxt == SETUP) && (r_apb != SETUP);
   assign w_beat        = (r_apb == ACCESS) ? r_rd_cnt + CW'(1) : r_rd_cnt;
   assign w_setup_data  = (r_apb == ACCESS) ? w_nxt_head : w_head;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_apb     <= AIDLE;
         r_awready <= 1'b0;
         r_base    <= '0;
         r_wr_cnt  <= '0;
         r_rd_cnt  <= '0;
         r_err     <= 1'b0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_apb     <= w_apb_nxt;
         r_awready <= (w_state_nxt == IDLE);
         if (w_aw_hs) begin
            r_base   <= awaddr;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_err    <= 1'b0;
         end
         if (w_push) begin
            r_wptr   <= r_wptr + PW'(1);
            r_wr_cnt <= r_wr_cnt + CW'(1);
         end
         if (w_pop) begin
            r_rptr   <= r_rptr + PW'(1);
            r_rd_cnt <= r_rd_cnt + CW'(1);
            r_err    <= r_err | pslverr;
         end
         r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
         if (w_enter_setup) begin
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= 1'b1;
            paddr   <= r_base + (ADDR_W'(w_beat) << 2);
            pwdata  <= w_setup_data;
         end else if (w_apb_nxt == ACCESS) begin
            penable <= 1'b1;
         end else if (w_apb_nxt == AIDLE) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axi_apb_write_slave.sv
// Directed bench for axi_apb_write_slave: AXI driver tasks, an APB completer model that records
// every finished transfer, and a scoreboard comparing those against hand-computed expectations.
module tb_axi_apb_write_slave;
   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] awaddr = '0;
   logic          awvalid = 1'b0;
   logic          awready;
   logic [DW-1:0] wdata = '0;
   logic          wvalid = 1'b0;
   logic          wready;
   logic          bvalid;
   logic          bready = 1'b0;
`ifdef AXI2APB_BRESP_EN
   logic [1:0]    bresp;
`endif
   logic [AW-1:0] paddr;
   logic          psel, penable, pwrite;
   logic [DW-1:0] pwdata;
   logic          pready = 1'b0;
   logic          pslverr = 1'b0;
   logic [1:0]    dbg_burst_state, dbg_apb_state;
   logic          dbg_err;

   axi_apb_write_slave dut (
      .clk(clk), .rst(rst),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready),
`ifdef AXI2APB_BRESP_EN
      .bresp(bresp),
`endif
      .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
      .pready(pready), .pslverr(pslverr),
      .o_dbg_burst_state(dbg_burst_state), .o_dbg_apb_state(dbg_apb_state), .o_dbg_err(dbg_err)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc++;

   initial begin
      #2000000;
      $display("FAIL watchdog: time %0t reached, limit 2000000", $time);
      $fatal(1);
   end

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad = 0;
   logic [AW-1:0] exp_addr_q[$];
   logic [DW-1:0] exp_data_q[$];
   logic [AW-1:0] got_addr_q[$];
   logic [DW-1:0] got_data_q[$];
   int setup_cyc_q[$];
   int w_hs_cyc_q[$];
   int pready_wait = 0;
   int err_beat = -1;
   int apb_beat = 0;
   int acc_cnt = 0;
   int b_cyc = 0;
   logic [AW-1:0] setup_addr;
   logic [DW-1:0] setup_data;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // APB completer: pready after pready_wait ACCESS cycles; records each finished transfer.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            pready = 1'b0; pslverr = 1'b0; acc_cnt = 0;
         end else if (psel && !penable) begin
            setup_cyc_q.push_back(cyc);
            setup_addr = paddr;
            setup_data = pwdata;
            pready = 1'b0; pslverr = 1'b0; acc_cnt = 0;
         end else if (psel && penable) begin
            pready  = (acc_cnt == pready_wait);
            pslverr = pready && (apb_beat == err_beat);
            if (pready) begin
               check("paddr_stable", paddr, setup_addr);
               check("pwdata_stable", pwdata, setup_data);
               check("pwrite", pwrite, 1'b1);
               got_addr_q.push_back(paddr);
               got_data_q.push_back(pwdata);
               apb_beat++;
            end
            acc_cnt++;
         end else begin
            pready = 1'b0; pslverr = 1'b0; acc_cnt = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_burst(input int wt, input int eb);
      got_addr_q.delete(); got_data_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
      setup_cyc_q.delete(); w_hs_cyc_q.delete();
      pready_wait = wt; err_beat = eb; apb_beat = 0;
   endtask

   task automatic expect_linear(input logic [AW-1:0] base, input logic [DW-1:0] d0);
      for (int i = 0; i < 4; i++) begin
         exp_addr_q.push_back(base + AW'(4 * i));
         exp_data_q.push_back(d0 + DW'(i));
      end
   endtask

   task automatic send_aw_w(input logic [AW-1:0] base, input logic [DW-1:0] d0);
      int n;
      awaddr = base; awvalid = 1'b1;
      n = 0;
      while (!awready && n < 100) begin @(negedge clk); n++; end
      if (!awready) check("aw_timeout", 0, 1);
      @(negedge clk);
      awvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wdata = d0 + DW'(i); wvalid = 1'b1;
         n = 0;
         while (!wready && n < 200) begin @(negedge clk); n++; end
         if (!wready) check("w_timeout", 0, 1);
         w_hs_cyc_q.push_back(cyc + 1);
         @(negedge clk);
      end
      wvalid = 1'b0;
   endtask

   task automatic wait_bvalid();
      int n;
      n = 0;
      while (!bvalid && n < 300) begin @(negedge clk); n++; end
      check("bvalid_seen", bvalid, 1'b1);
      b_cyc = cyc;
   endtask

   task automatic finish_b(input int bdelay);
      for (int i = 0; i < bdelay; i++) begin
         check("b_hold{bvalid,awready,psel}", {bvalid, awready, psel}, 3'b100);
         @(negedge clk);
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      check("b_done{bvalid,awready}", {bvalid, awready}, 2'b01);
   endtask

   task automatic check_transfers();
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      check("n_xfers", got_addr_q.size(), exp_addr_q.size());
      while (exp_addr_q.size() > 0) begin
         a = exp_addr_q.pop_front();
         d = exp_data_q.pop_front();
         if (got_addr_q.size() > 0) begin
            check("paddr", got_addr_q.pop_front(), a);
            check("pwdata", got_data_q.pop_front(), d);
         end
      end
   endtask

   task automatic run_burst(input logic [AW-1:0] base, input logic [DW-1:0] d0, input int wt,
                            input int eb, input int bdelay, input logic [1:0] exp_resp);
      start_burst(wt, eb);
      expect_linear(base, d0);
      send_aw_w(base, d0);
      wait_bvalid();
      check("err_flag", dbg_err, exp_resp[1]);
`ifdef AXI2APB_BRESP_EN
      check("bresp", bresp, exp_resp);
`endif
      check_transfers();
      finish_b(bdelay);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      repeat (2) @(negedge clk);
      check("rst_ctrl", {awready, wready, bvalid, psel, penable, pwrite}, 6'b0);
      check("rst_paddr", paddr, 0);
      check("rst_pwdata", pwdata, 0);
      check("rst_states", {dbg_burst_state, dbg_apb_state, dbg_err}, 5'b0);
      rst = 1'b0;
      @(negedge clk);
      check("awready_after_rst", awready, 1'b1);

      // Back-to-back 2-cycle transfers with hand-computed addresses and timing.
      start_burst(0, -1);
      exp_addr_q = '{32'hAABBCCDD, 32'hAABBCCE1, 32'hAABBCCE5, 32'hAABBCCE9};
      exp_data_q = '{32'h10000000, 32'h10000001, 32'h10000002, 32'h10000003};
      send_aw_w(32'hAABBCCDD, 32'h10000000);
      wait_bvalid();
      check("n_setups", setup_cyc_q.size(), 4);
      check("psel_latency", setup_cyc_q[0], w_hs_cyc_q[0] + 1);
      for (int i = 1; i < 4; i++) check("b2b_setup", setup_cyc_q[i], setup_cyc_q[0] + 2 * i);
      check("b_latency", b_cyc, setup_cyc_q[3] + 2);
      check_transfers();
      finish_b(0);

      // Slow completer: FIFO fills before the first pop, then everything drains in order.
      start_burst(3, -1);
      expect_linear(32'h0000_1000, 32'h2000_0000);
      send_aw_w(32'h0000_1000, 32'h2000_0000);
      check("wready_full", wready, 1'b0);
      check("none_popped_yet", got_addr_q.size(), 0);
      wait_bvalid();
      check("slow_spacing", setup_cyc_q[3] - setup_cyc_q[0], 15);
      check_transfers();
      finish_b(0);

      // B held off for 5 cycles, then a second burst.
      run_burst(32'h0000_2000, 32'h3000_0000, 0, -1, 5, 2'b00);
      run_burst(32'h0000_3000, 32'h3100_0000, 1, -1, 0, 2'b00);

      // Address wrap at 2^32.
      start_burst(0, -1);
      exp_addr_q = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004};
      exp_data_q = '{32'h40000000, 32'h40000001, 32'h40000002, 32'h40000003};
      send_aw_w(32'hFFFFFFF8, 32'h40000000);
      wait_bvalid();
      check_transfers();
      finish_b(0);

      // Reset after the second APB transfer abandons the burst.
      start_burst(0, -1);
      send_aw_w(32'h0000_5000, 32'h5000_0000);
      begin
         int n;
         n = 0;
         while (got_addr_q.size() < 2 && n < 100) begin @(negedge clk); n++; end
         check("two_xfers_before_rst", got_addr_q.size() >= 2, 1'b1);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_ctrl", {awready, wready, bvalid, psel, penable, pwrite}, 6'b0);
      check("midrst_paddr_pwdata", {paddr, pwdata}, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("awready_after_midrst", awready, 1'b1);
      check("no_b_owed", bvalid, 1'b0);
      run_burst(32'h0000_6000, 32'h6000_0000, 0, -1, 0, 2'b00);

      // pslverr on the second beat.
      run_burst(32'h0000_7000, 32'h7000_0000, 1, 1, 0, 2'b10);
      run_burst(32'h0000_8000, 32'h8000_0000, 0, -1, 0, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
